// File: rtl/viterbi_decoder_k.sv
// Hard-decision rate-1/2 Viterbi decoder: full ACS over 2^(K-1) states with register-exchange survivors.
// Optional erasure input: define VITERBI_ERASE_EN to add the in_erase port.

module viterbi_decoder_k #(
   parameter int             K        = 3,
   parameter logic [K-1:0]   G0       = 3'b111,
   parameter logic [K-1:0]   G1       = 3'b101,
   parameter int             TB_DEPTH = 15,
   parameter int             MW       = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] in_sym,
   input  logic       in_first,
   input  logic       in_last,
`ifdef VITERBI_ERASE_EN
   input  logic [1:0] in_erase,
`endif
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_bit,
   output logic       out_last
);

   localparam int S  = 1 << (K - 1);
   localparam int CW = $clog2(TB_DEPTH);
   localparam logic [MW-1:0] INIT_M    = {2'b01, {(MW-2){1'b0}}};
   localparam logic [CW-1:0] LAST_FILL = CW'(TB_DEPTH - 1);

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t              state_r;
   logic [MW-1:0]       metric_r     [S];
   logic [TB_DEPTH-1:0] path_r       [S];
   logic [MW-1:0]       metric_raw_s [S];
   logic [MW-1:0]       metric_nx_s  [S];
   logic [TB_DEPTH-1:0] path_nx_s    [S];
   logic [CW-1:0]       count_r;
   logic [CW-1:0]       rem_r;
   logic [CW-1:0]       base_cnt_s;
   logic [TB_DEPTH-1:0] flush_r;
   logic                out_valid_r;
   logic                out_bit_r;
   logic                out_last_r;
   logic [1:0]          erase_s;
   logic                accept_s;
   logic                out_fire_s;
   logic                full_s;
   logic                all_msb_s;
   logic                best_bit_s;
   logic [MW-1:0]       best_m_s;
   logic                short_bit_s;
   logic                flush_bit_s;

   function automatic logic parity(input logic [K-1:0] v);
      return ^v;
   endfunction

   function automatic logic [1:0] expected_pair(input logic [K-1:0] r);
      return {parity(r & G0), parity(r & G1)};
   endfunction

   // Erased bits are masked out of the Hamming distance.
   function automatic logic [1:0] branch_metric(input logic [1:0] sym, input logic [1:0] expct,
                                                input logic [1:0] erase);
      logic [1:0] diff;
      diff = (sym ^ expct) & ~erase;
      return {1'b0, diff[1]} + {1'b0, diff[0]};
   endfunction

   function automatic logic [MW-1:0] init_metric(input logic [K-2:0] st);
      return (st == {(K-1){1'b0}}) ? {MW{1'b0}} : INIT_M;
   endfunction

`ifdef VITERBI_ERASE_EN
   assign erase_s = in_erase;
`else
   assign erase_s = 2'b00;
`endif

   assign in_ready   = !rst && (state_r != FLUSH) && (!out_valid_r || out_ready);
   assign accept_s   = in_valid && in_ready;
   assign out_fire_s = out_valid_r && out_ready;
   assign out_valid  = out_valid_r;
   assign out_bit    = out_bit_r;
   assign out_last   = out_last_r;

   // Add-compare-select for every next state; predecessors differ only in their LSB.
   always_comb begin : acs
      logic [K-2:0]        n_v;
      logic [K-2:0]        p0_v;
      logic [K-2:0]        p1_v;
      logic [MW-1:0]       c0_v;
      logic [MW-1:0]       c1_v;
      logic [TB_DEPTH-1:0] pp0_v;
      logic [TB_DEPTH-1:0] pp1_v;
      logic [TB_DEPTH-1:0] pick_v;
      n_v    = {(K-1){1'b0}};
      p0_v   = {(K-1){1'b0}};
      p1_v   = {(K-1){1'b0}};
      c0_v   = {MW{1'b0}};
      c1_v   = {MW{1'b0}};
      pp0_v  = {TB_DEPTH{1'b0}};
      pp1_v  = {TB_DEPTH{1'b0}};
      pick_v = {TB_DEPTH{1'b0}};
      for (int n = 0; n < S; n++) begin
         n_v   = (K-1)'(n);
         p0_v  = {n_v[K-3:0], 1'b0};
         p1_v  = {n_v[K-3:0], 1'b1};
         pp0_v = in_first ? {TB_DEPTH{1'b0}} : path_r[p0_v];
         pp1_v = in_first ? {TB_DEPTH{1'b0}} : path_r[p1_v];
         c0_v  = (in_first ? init_metric(p0_v) : metric_r[p0_v])
               + {{(MW-2){1'b0}}, branch_metric(in_sym, expected_pair({n_v[K-2], p0_v}), erase_s)};
         c1_v  = (in_first ? init_metric(p1_v) : metric_r[p1_v])
               + {{(MW-2){1'b0}}, branch_metric(in_sym, expected_pair({n_v[K-2], p1_v}), erase_s)};
         if (c1_v < c0_v) begin
            metric_raw_s[n] = c1_v;
            pick_v          = pp1_v;
         end else begin
            metric_raw_s[n] = c0_v;
            pick_v          = pp0_v;
         end
         path_nx_s[n] = {pick_v[TB_DEPTH-2:0], n_v[K-2]};
      end
   end

   // Normalization and best-state selection (ties resolve to the lowest index).
   always_comb begin : norm_best
      logic lt_v;
      lt_v      = 1'b0;
      all_msb_s = 1'b1;
      for (int n = 0; n < S; n++) begin
         all_msb_s = all_msb_s & metric_raw_s[n][MW-1];
      end
      for (int n = 0; n < S; n++) begin
         metric_nx_s[n] = all_msb_s ? {1'b0, metric_raw_s[n][MW-2:0]} : metric_raw_s[n];
      end
      best_m_s   = metric_nx_s[0];
      best_bit_s = path_nx_s[0][TB_DEPTH-1];
      for (int n = 1; n < S; n++) begin
         lt_v       = metric_nx_s[n] < best_m_s;
         best_bit_s = lt_v ? path_nx_s[n][TB_DEPTH-1] : best_bit_s;
         best_m_s   = lt_v ? metric_nx_s[n] : best_m_s;
      end
   end

   // Frame bookkeeping: fill count, whether this accept produces a regular output, flush bit taps.
   always_comb begin
      base_cnt_s  = in_first ? {CW{1'b0}} : count_r;
      full_s      = ((state_r == RUN) && !in_first) || (base_cnt_s == LAST_FILL);
      short_bit_s = path_nx_s[0][base_cnt_s];
      flush_bit_s = flush_r[rem_r - {{(CW-1){1'b0}}, 1'b1}];
   end

   // Decoder state, survivor memory and registered output stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= FILL;
         count_r     <= {CW{1'b0}};
         rem_r       <= {CW{1'b0}};
         flush_r     <= {TB_DEPTH{1'b0}};
         out_valid_r <= 1'b0;
         out_bit_r   <= 1'b0;
         out_last_r  <= 1'b0;
         for (int i = 0; i < S; i++) begin
            metric_r[i] <= (i == 0) ? {MW{1'b0}} : INIT_M;
            path_r[i]   <= {TB_DEPTH{1'b0}};
         end
      end else begin
         if (accept_s) begin
            for (int i = 0; i < S; i++) begin
               metric_r[i] <= metric_nx_s[i];
               path_r[i]   <= path_nx_s[i];
            end
         end
         case (state_r)
            FILL, RUN: begin
               if (accept_s) begin
                  if (in_last) begin
                     // Tail-terminated: remaining bits come from the state-0 survivor.
                     state_r     <= FLUSH;
                     count_r     <= {CW{1'b0}};
                     flush_r     <= path_nx_s[0];
                     out_valid_r <= 1'b1;
                     if (full_s) begin
                        out_bit_r  <= best_bit_s;
                        rem_r      <= LAST_FILL;
                        out_last_r <= 1'b0;
                     end else begin
                        out_bit_r  <= short_bit_s;
                        rem_r      <= base_cnt_s;
                        out_last_r <= (base_cnt_s == {CW{1'b0}});
                     end
                  end else if (full_s) begin
                     state_r     <= RUN;
                     count_r     <= {CW{1'b0}};
                     out_valid_r <= 1'b1;
                     out_bit_r   <= best_bit_s;
                     out_last_r  <= 1'b0;
                  end else begin
                     state_r     <= FILL;
                     count_r     <= base_cnt_s + {{(CW-1){1'b0}}, 1'b1};
                     out_valid_r <= 1'b0;
                     out_last_r  <= 1'b0;
                  end
               end else if (out_fire_s) begin
                  out_valid_r <= 1'b0;
                  out_last_r  <= 1'b0;
               end else begin
                  out_valid_r <= out_valid_r;
               end
            end
            FLUSH: begin
               if (out_fire_s) begin
                  if (rem_r == {CW{1'b0}}) begin
                     state_r     <= FILL;
                     count_r     <= {CW{1'b0}};
                     out_valid_r <= 1'b0;
                     out_last_r  <= 1'b0;
                  end else begin
                     out_bit_r  <= flush_bit_s;
                     rem_r      <= rem_r - {{(CW-1){1'b0}}, 1'b1};
                     out_last_r <= (rem_r == {{(CW-1){1'b0}}, 1'b1});
                  end
               end else begin
                  rem_r <= rem_r;
               end
            end
            default: begin
               state_r     <= FILL;
               out_valid_r <= 1'b0;
               out_last_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_viterbi_decoder_k.sv
// Directed bench for viterbi_decoder_k (K=3, G0=111, G1=101, TB_DEPTH=15): encodes frames, checks decoded bits and timing.

module tb_viterbi_decoder_k;
   localparam int K    = 3;
   localparam int TBD  = 15;
   localparam int MAXN = 2048;
   localparam logic [K-1:0] G0 = 3'b111;
   localparam logic [K-1:0] G1 = 3'b101;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_sym;
   logic       in_first;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic       out_bit;
   logic       out_last;
`ifdef VITERBI_ERASE_EN
   logic [1:0] in_erase;
`endif

   int errors;
   int checks;

   typedef struct {
      string name;
      int    n_data;
      int    flip;
      int    stall;
      int    exp_out;
      int    exp_first;
   } vec_t;
   vec_t vecs [7];

   bit         ubits    [MAXN];
   logic [1:0] syms     [MAXN];
   bit         got_bits [MAXN];
   int         got;
   int         last_pos;
   int         last_cnt;
   int         first_at;
   int         hold_bad;
   int         flush_bad;
   int         bit_err;
   bit         timed_out;

   viterbi_decoder_k #(.K(K), .G0(G0), .G1(G1), .TB_DEPTH(TBD), .MW(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sym    (in_sym),
      .in_first  (in_first),
      .in_last   (in_last),
`ifdef VITERBI_ERASE_EN
      .in_erase  (in_erase),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bit   (out_bit),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input string nm, input int nd, input int fl, input int st,
                          input int eo, input int ef);
      vecs[i].name      = nm;
      vecs[i].n_data    = nd;
      vecs[i].flip      = fl;
      vecs[i].stall     = st;
      vecs[i].exp_out   = eo;
      vecs[i].exp_first = ef;
   endtask

   // Encode nd random bits plus a zero tail, stream them, and capture every output handshake.
   task automatic run_frame(input int nd, input int flip, input int stall, input int abort_at);
      int         n;
      int         acc;
      int         cyc;
      logic [K-2:0] s;
      logic [K-1:0] r;
      bit         u;
      bit         done;
      bit         flushing;
      bit         held;
      bit         hb;
      bit         hl;
      bit         fin;
      bit         fout;
      bit         lfire;
      bit         olast;
      n = nd + K - 1;
      s = '0;
      for (int i = 0; i < n; i++) begin
         u        = (i < nd) ? bit'($urandom_range(0, 1)) : 1'b0;
         r        = {u, s};
         ubits[i] = u;
         syms[i]  = {^(r & G0), ^(r & G1)};
         if (flip > 0 && (i % flip) == 3)
            syms[i] = syms[i] ^ ((((i / flip) % 2) == 1) ? 2'b01 : 2'b10);
         s = r[K-1:1];
      end
      got = 0; last_pos = -1; last_cnt = 0; first_at = -1;
      hold_bad = 0; flush_bad = 0; bit_err = 0;
      acc = 0; cyc = 0; done = 1'b0; flushing = 1'b0; held = 1'b0;
      while (!done && cyc < n * 6 + 100) begin
         if (acc < n && (abort_at == 0 || acc < abort_at)) begin
            in_valid = 1'b1;
            in_sym   = syms[acc];
            in_first = (acc == 0);
            in_last  = (acc == n - 1);
         end else begin
            in_valid = 1'b0;
            in_sym   = 2'b00;
            in_first = 1'b0;
            in_last  = 1'b0;
         end
         out_ready = (stall == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall);
         #1;
         fin   = in_valid && in_ready;
         fout  = out_valid && out_ready;
         lfire = fin && in_last;
         olast = fout && out_last;
         if (flushing && in_ready) flush_bad++;
         held = out_valid && !out_ready;
         hb   = out_bit;
         hl   = out_last;
         if (held && in_ready) hold_bad++;
         if (fout) begin
            if (got < MAXN) got_bits[got] = out_bit;
            if (out_last) begin
               last_pos = got;
               last_cnt++;
            end
            got++;
         end
         @(posedge clk);
         #1;
         if (fin) acc++;
         if (lfire) flushing = 1'b1;
         if (olast) begin
            flushing = 1'b0;
            done     = 1'b1;
         end
         if (held && (!out_valid || out_bit != hb || out_last != hl)) hold_bad++;
         if (first_at < 0 && out_valid) first_at = acc;
         if (abort_at > 0 && acc >= abort_at) done = 1'b1;
         cyc++;
      end
      timed_out = !done;
      in_valid  = 1'b0;
      in_first  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < n && i < got; i++)
         if (got_bits[i] != ubits[i]) bit_err++;
   endtask

   initial begin
      errors = 0; checks = 0;
      rst = 1'b1; in_valid = 1'b0; in_sym = 2'b00; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
`ifdef VITERBI_ERASE_EN
      in_erase = 2'b00;
`endif
      //        name        data  flip stall outs first
      set_vec(0, "clean64",    64,  0,  0,   66,  15);
      set_vec(1, "flip8",      64,  8,  0,   66,  15);
      set_vec(2, "stall50",    64,  0, 50,   66,  15);
      set_vec(3, "short5",      3,  0,  0,    5,   5);
      set_vec(4, "short14",    12,  0, 30,   14,  14);
      set_vec(5, "exact15",    13,  0,  0,   15,  15);
      set_vec(6, "long2000", 1998,  8,  0, 2000,  15);

      #2;
      check("reset_in_ready", in_ready, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_last", out_last, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("release_in_ready", in_ready, 1);
      check("release_out_valid", out_valid, 0);
      check("release_out_bit", out_bit, 0);

      for (int i = 0; i < 7; i++) begin
         run_frame(vecs[i].n_data, vecs[i].flip, vecs[i].stall, 0);
         check({vecs[i].name, "_timeout"}, timed_out, 0);
         check({vecs[i].name, "_count"}, got, vecs[i].exp_out);
         check({vecs[i].name, "_biterr"}, bit_err, 0);
         check({vecs[i].name, "_lastpos"}, last_pos, vecs[i].exp_out - 1);
         check({vecs[i].name, "_lastcnt"}, last_cnt, 1);
         check({vecs[i].name, "_first"}, first_at, vecs[i].exp_first);
         check({vecs[i].name, "_hold"}, hold_bad, 0);
         check({vecs[i].name, "_flushready"}, flush_bad, 0);
         #1;
         check({vecs[i].name, "_readyafter"}, in_ready, 1);
      end

      // in_first mid-RUN restarts the frame with a fresh fill count.
      run_frame(40, 0, 0, 25);
      @(posedge clk);
      #1;
      check("restart_idle_valid", out_valid, 0);
      run_frame(20, 0, 0, 0);
      check("restart_count", got, 22);
      check("restart_biterr", bit_err, 0);
      check("restart_first", first_at, TBD);
      check("restart_lastpos", last_pos, 21);

      // Asynchronous reset in the middle of a frame.
      run_frame(38, 0, 0, 20);
      check("midrst_valid_before", out_valid, 1);
      rst = 1'b1;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("midrst_release_ready", in_ready, 1);
      check("midrst_release_last", out_last, 0);
      run_frame(30, 0, 0, 0);
      check("midrst_count", got, 32);
      check("midrst_biterr", bit_err, 0);
      check("midrst_first", first_at, TBD);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
